// File: rtl/bnn_stream_feeder.sv
// bnn_stream_feeder
//   On-chip stimulus source for the BNN accelerator. It holds the binary FC
//   weights (one bit stream per output channel) and two conv weight banks,
//   all written through a bit-serial load port. It binarises an incoming
//   pixel stream and serialises weight bits on the accelerator's request
//   strobes. Every output path is registered and has one cycle of latency.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   start            enables the pixel path
//   ld_en/ld_sel/ld_addr/ld_data
//                    bit write port. ld_sel selects the target:
//                    0..NUM_FC-1 = FC channel, NUM_FC = bank0, NUM_FC+1 = bank1
//   pix_valid/pix_data  pixel input
//   pix_bin/pix_bin_valid/image_done   binarised pixel and end-of-image pulse
//   fc_ivalid        FC request; weight_fc_out[c] = channel c bit, fc_wrap = last bit
//   weight_en_0/1    conv phase requests; conv_rewind clears the conv pointers
//   weight_conv_out  conv weight bit
module bnn_stream_feeder #(
    parameter int NUM_FC     = 10,
    parameter int FC_LEN     = 1024,
    parameter int CONV_K     = 9,
    parameter int CONV_B1    = 64,
    parameter int PIX_W      = 8,
    parameter int PIX_THRESH = 128,
    parameter int IMG_PIX    = 784,
    parameter int SEL_W      = $clog2(NUM_FC + 2),
    parameter int AW         = $clog2((FC_LEN > 2*CONV_K)
                                      ? ((FC_LEN > CONV_B1) ? FC_LEN : CONV_B1)
                                      : ((2*CONV_K > CONV_B1) ? 2*CONV_K : CONV_B1))
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              ld_en,
    input  logic [SEL_W-1:0]  ld_sel,
    input  logic [AW-1:0]     ld_addr,
    input  logic              ld_data,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_bin,
    output logic              pix_bin_valid,
    output logic              image_done,
    input  logic              fc_ivalid,
    output logic [NUM_FC-1:0] weight_fc_out,
    output logic              fc_wrap,
    input  logic              weight_en_0,
    input  logic              weight_en_1,
    input  logic              conv_rewind,
    output logic              weight_conv_out
);

    localparam int FC_AW = (FC_LEN > 1) ? $clog2(FC_LEN) : 1;
    localparam int B0_AW = (2*CONV_K > 1) ? $clog2(2*CONV_K) : 1;
    localparam int B1_AW = (CONV_B1 > 1) ? $clog2(CONV_B1) : 1;
    localparam int CC_W  = $clog2(2*CONV_K + 1);
    localparam int PC_W  = (IMG_PIX > 1) ? $clog2(IMG_PIX) : 1;

    localparam logic [FC_AW-1:0] FC_LAST = FC_AW'(FC_LEN - 1);
    localparam logic [B1_AW-1:0] B1_LAST = B1_AW'(CONV_B1 - 1);
    localparam logic [PC_W-1:0]  PIX_LAST = PC_W'(IMG_PIX - 1);
    localparam logic [CC_W-1:0]  K_C     = CC_W'(CONV_K);
    localparam logic [CC_W-1:0]  K2_C    = CC_W'(2*CONV_K);
    // One extra bit so a threshold of 2**PIX_W still compares correctly.
    localparam logic [PIX_W:0]   THR_C   = (PIX_W+1)'(PIX_THRESH);

    logic [FC_LEN-1:0]   fcmem [NUM_FC];
    logic [2*CONV_K-1:0] bank0;
    logic [CONV_B1-1:0]  bank1;

    logic [FC_AW-1:0] fc_ptr;
    logic [PC_W-1:0]  pix_cnt;
    logic [CC_W-1:0]  conv_cnt;
    logic [B1_AW-1:0] b1_ptr;

    // Weight storage is deliberately not reset so weights survive a stream abort.
    // Reads below sample the pre-write contents, so a same-cycle load is seen
    // one cycle later.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            for (int c = 0; c < NUM_FC; c++) begin
                if (ld_sel == SEL_W'(c) && 32'(ld_addr) < FC_LEN)
                    fcmem[c][ld_addr[FC_AW-1:0]] <= ld_data;
            end
            if (ld_sel == SEL_W'(NUM_FC) && 32'(ld_addr) < 2*CONV_K)
                bank0[ld_addr[B0_AW-1:0]] <= ld_data;
            if (ld_sel == SEL_W'(NUM_FC + 1) && 32'(ld_addr) < CONV_B1)
                bank1[ld_addr[B1_AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_bin       <= 1'b0;
            pix_bin_valid <= 1'b0;
            image_done    <= 1'b0;
            pix_cnt       <= '0;
        end else begin
            image_done <= 1'b0;
            if (pix_valid && start) begin
                pix_bin       <= ({1'b0, pix_data} < THR_C);
                pix_bin_valid <= 1'b1;
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt    <= '0;
                    image_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end else begin
                pix_bin_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight_fc_out <= '0;
            fc_wrap       <= 1'b0;
            fc_ptr        <= '0;
        end else begin
            fc_wrap <= 1'b0;
            if (fc_ivalid) begin
                for (int c = 0; c < NUM_FC; c++)
                    weight_fc_out[c] <= fcmem[c][fc_ptr];
                if (fc_ptr == FC_LAST) begin
                    fc_ptr  <= '0;
                    fc_wrap <= 1'b1;
                end else begin
                    fc_ptr <= fc_ptr + 1'b1;
                end
            end
        end
    end

    // conv_cnt walks bank0: phase 0 may only consume the first CONV_K taps,
    // phase 1 the rest. Once a phase has used up its share, any request is
    // served from the cyclic bank1 and conv_cnt stays put (saturating at 2*CONV_K).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            weight_conv_out <= 1'b0;
            conv_cnt        <= '0;
            b1_ptr          <= '0;
        end else if (conv_rewind) begin
            conv_cnt <= '0;
            b1_ptr   <= '0;
        end else if (weight_en_0 && conv_cnt < K_C) begin
            weight_conv_out <= bank0[conv_cnt[B0_AW-1:0]];
            conv_cnt        <= conv_cnt + 1'b1;
        end else if (weight_en_1 && conv_cnt < K2_C) begin
            weight_conv_out <= bank0[conv_cnt[B0_AW-1:0]];
            conv_cnt        <= conv_cnt + 1'b1;
        end else if (weight_en_0 || weight_en_1) begin
            weight_conv_out <= bank1[b1_ptr];
            b1_ptr          <= (b1_ptr == B1_LAST) ? '0 : b1_ptr + 1'b1;
        end
    end

endmodule

// File: doc/bnn_stream_feeder.md
Name: bnn_stream_feeder

Overview:
- On-chip replacement for the file-driven stimulus feeding the BNN top.
- Holds per-channel binary FC weights and two conv weight banks, loaded through a bit-serial load port.
- Binarises an incoming pixel stream.
- Serialises weight bits into the accelerator on its fc_ivalid / weight_en_0 / weight_en_1 strobes.
- Generalised in FC channel count, stream lengths, conv kernel size and pixel width/threshold.

Parameters:
- NUM_FC, 10, number of FC output channels (one weight bit per channel per fc_ivalid).
- FC_LEN, 1024, weight bits per FC channel.
- CONV_K, 9, conv kernel taps; bank0 depth is 2*CONV_K.
- CONV_B1, 64, bank1 depth (cyclic).
- PIX_W, 8, pixel width.
- PIX_THRESH, 128, binarisation threshold.
- IMG_PIX, 784, pixels per image.
- SEL_W, $clog2(NUM_FC+2), width of ld_sel.
- AW, $clog2(max(FC_LEN,2*CONV_K,CONV_B1)), width of ld_addr.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  enables pixel counting.
- ld_en  in  1  load strobe.
- ld_sel  in  SEL_W  target: 0..NUM_FC-1 = FC channel, NUM_FC = conv bank0, NUM_FC+1 = conv bank1.
- ld_addr  in  AW  bit address within target.
- ld_data  in  1  bit to write.
- pix_valid  in  1  pixel strobe.
- pix_data  in  PIX_W  unsigned pixel.
- pix_bin  out  1  binarised pixel.
- pix_bin_valid  out  1  pix_bin qualifier.
- image_done  out  1  one-cycle pulse on the last pixel of an image.
- fc_ivalid  in  1  FC weight request.
- weight_fc_out  out  NUM_FC  bit c = channel c weight.
- fc_wrap  out  1  one-cycle pulse with the last FC bit.
- weight_en_0  in  1  conv phase-0 request.
- weight_en_1  in  1  conv phase-1 request.
- conv_rewind  in  1  synchronous clear of the conv counters.
- weight_conv_out  out  1  conv weight bit.

Behaviour:
- Reset (rstn low, asynchronous):
  - All outputs 0.
  - fc_ptr, pix_cnt, conv_cnt, b1_ptr cleared.
  - Memory contents are not reset.
- Reset mid-operation aborts any stream in progress; after release, streams restart from address 0.
- Load port:
  - On ld_en, mem[ld_sel][ld_addr] <= ld_data.
  - ld_sel > NUM_FC+1 or ld_addr ≥ the target's depth: write ignored.
  - A load to an address read in the same cycle returns the old value; the new value is visible the next cycle.
  - Loads are legal while streaming.
- Pixel path, one-cycle latency:
  - pix_valid && start: pix_bin <= (pix_data < PIX_THRESH); pix_bin_valid <= 1.
  - pix_cnt increments; at IMG_PIX-1, image_done pulses with that pixel's pix_bin_valid and pix_cnt wraps to 0.
  - Otherwise pix_bin_valid <= 0 and pix_bin holds.
  - With start low, pixels are ignored.
- FC path, one-cycle latency:
  - fc_ivalid: weight_fc_out[c] <= fcmem[c][fc_ptr] for every channel simultaneously.
  - fc_ptr increments, wrapping FC_LEN-1 → 0.
  - fc_wrap pulses in the cycle the bit from address FC_LEN-1 is presented.
  - Without fc_ivalid, weight_fc_out holds.
- Conv path, one-cycle latency. Priority is evaluated in this order each cycle:
  1. weight_en_0 && conv_cnt < CONV_K: out <= bank0[conv_cnt]; conv_cnt++.
  2. Else weight_en_1 && conv_cnt < 2*CONV_K: out <= bank0[conv_cnt]; conv_cnt++.
  3. Else weight_en_0 || weight_en_1: out <= bank1[b1_ptr]; b1_ptr increments, wrapping CONV_B1-1 → 0; conv_cnt holds.
  4. Else: out holds.
- Conv boundary cases:
  - weight_en_0 with CONV_K ≤ conv_cnt < 2*CONV_K falls to step 3 (bank1).
  - Both enables high resolve per the priority order above.
- conv_rewind clears conv_cnt and b1_ptr and overrides any conv request in the same cycle; the output holds that cycle.
- conv_cnt saturates at 2*CONV_K.

Test Plan:
1. Load fcmem[c][a] = a[0]^c[0] for all c, a. Hold fc_ivalid for FC_LEN+2 cycles → first output 10'b1010101010 (bit c = c[0]); every output equals ptr[0]^c[0]; fc_wrap pulses exactly once, on the 1024th output; outputs 1025 and 1026 restart from address 0.
2. Stream 784 pixels of value 127, 128, 0, 255 (cyclic) with start=1 → pix_bin 1,0,1,0; image_done on pixel 784 only. Same stream with start=0 → pix_bin_valid stays 0.
3. Load bank0 with 18 bits (0x2A5A5 pattern) and bank1 with alternating 1,0. Issue 9 weight_en_0, then 9 weight_en_1, then 70 weight_en_0 → first 18 outputs equal bank0[0..17]; the remaining outputs alternate 1,0; b1_ptr wraps at 64.
4. Issue 10 weight_en_0 (the 10th comes from bank1[0]), then weight_en_1 → bank0[9]; pulse conv_rewind → the next weight_en_0 returns bank0[0].
5. Write fcmem[3][5] in the same cycle fc_ptr=5 is read → old bit output; after rewrap, the new bit is output.
6. Assert rstn low mid-stream (fc_ptr=300, conv_cnt=12) → all outputs 0 immediately; after release, the first fc_ivalid returns address 0 and the first weight_en_0 returns bank0[0].
